reg_shift_sequencer: RTL

Multi-cycle sequencer for register-specified shifts (shift amount read from Rs, 0–255) in the Execute stage, the case the single-cycle Val2 path does not cover. Accepts an operand, shift type and 8-bit amount, applies the shift in chunks of at most 8 bit positions per cycle, and returns the 32-bit result plus the ARM shifter carry-out. The pipeline holds Execute while `busy` is high.

---
 rtl/reg_shift_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/reg_shift_sequencer.sv
// Multi-cycle shifter for register-specified shift amounts: ARM LSL/LSR/ASR/ROR
// semantics, up to 8 bit positions per cycle, ARM shifter carry-out.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | applying up to 8 bit positions per cycle, busy high
// DONE  | one-cycle done pulse, result/carry_out valid, may accept a new start
module reg_shift_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] op,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  amount,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] acc;
    logic        acc_c;
    logic [1:0]  type_q;
    logic [5:0]  remaining;

    logic        accept;
    logic [5:0]  eff;
    logic [3:0]  step;
    logic [31:0] step_val;
    logic        step_c;

    // Effective count: 33 stands for "everything shifted out, carry 0".
    always_comb begin
        eff = '0;
        case (shift_type)
            SH_LSL, SH_LSR: eff = (amount > 8'd33) ? 6'd33 : amount[5:0];
            SH_ASR:         eff = (amount > 8'd32) ? 6'd32 : amount[5:0];
            default: begin
                if (amount == 8'd0)
                    eff = 6'd0;
                else if (amount[4:0] == 5'd0)
                    eff = 6'd32;
                else
                    eff = {1'b0, amount[4:0]};
            end
        endcase
    end

    assign step = (remaining > 6'd8) ? 4'd8 : remaining[3:0];

    // step successive 1-bit shifts; carry tracks the last bit shifted out.
    always_comb begin
        step_val = acc;
        step_c   = acc_c;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(step)) begin
                case (type_q)
                    SH_LSL: begin
                        step_c   = step_val[31];
                        step_val = {step_val[30:0], 1'b0};
                    end
                    SH_LSR: begin
                        step_c   = step_val[0];
                        step_val = {1'b0, step_val[31:1]};
                    end
                    SH_ASR: begin
                        step_c   = step_val[0];
                        step_val = {step_val[31], step_val[31:1]};
                    end
                    default: begin
                        step_c   = step_val[0];
                        step_val = {step_val[0], step_val[31:1]};
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    accept     = 1'b1;
                    state_next = (eff == 6'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (remaining == {2'b00, step})
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // result/carry_out only change on the edge entering DONE, so a flush
    // leaves the last completed values visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            acc_c     <= 1'b0;
            type_q    <= SH_LSL;
            remaining <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            acc       <= op;
            acc_c     <= carry_in;
            type_q    <= shift_type;
            remaining <= eff;
            if (eff == 6'd0) begin
                result    <= op;
                carry_out <= carry_in;
            end
        end else if (state == SHIFT) begin
            acc       <= step_val;
            acc_c     <= step_c;
            remaining <= remaining - {2'b00, step};
            if (state_next == DONE) begin
                result    <= step_val;
                carry_out <= step_c;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
